reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, 8, bits per register.
REQ-002 Parameter ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of independent read ports (1..8).
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_r_en  in  NUM_RD  per-port read request.
REQ-007 i_r_address  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 o_data  out  NUM_RD*DATA_W  packed registered read data, port k at [k*DATA_W +: DATA_W].
REQ-009 o_valid  out  NUM_RD  per-port read-data valid.
REQ-010 i_write  in  1  write enable.
REQ-011 i_w_address  in  ADDR_W  write address.
REQ-012 i_data  in  DATA_W  write data.
REQ-013 i_clear  in  1  one-cycle pulse starting the background clear sweep.
REQ-014 o_busy  out  1  high while the clear sweep runs.

Function
REQ-015 Read latency exactly 1 cycle: i_r_en[k] at edge N gives o_data[k] and o_valid[k]=1 after edge N.
REQ-016 o_valid[k]=0 on any cycle without an accepted read; o_data[k] holds its last value.
REQ-017 Reads and writes are independent; a write does not block any read port.
REQ-018 Write commits registers[i_w_address] <= i_data at the edge when i_write=1 and FSM is IDLE.
REQ-019 Multiple ports reading the same address in one cycle all return identical data.
REQ-020 FSM states IDLE, CLEAR; IDLE->CLEAR on i_clear=1; CLEAR->IDLE after writing address DEPTH-1.
REQ-021 In CLEAR, a ptr counter starting at 0 zeroes registers[ptr] each cycle, incrementing by 1; the sweep takes exactly DEPTH cycles.
REQ-022 o_busy=1 exactly while state is CLEAR (registered, asserted the cycle after i_clear).
REQ-023 During CLEAR: i_write ignored (data dropped), i_r_en ignored (o_valid=0), i_clear ignored.
REQ-024 i_clear and i_write in the same IDLE cycle: the write commits, then the sweep starts and zeroes it.
REQ-025 ptr width ADDR_W; no wrap past DEPTH-1.

Reset
REQ-026 i_rst=1 at an edge: all registers 0, o_data 0, o_valid 0, state IDLE, ptr 0, o_busy 0.
REQ-027 Reset has priority over write, read and clear; reset mid-sweep aborts it and returns to IDLE.
REQ-028 Outputs are defined from the first reset edge; no reliance on initial blocks.

Configuration
REQ-029 Macro REG_FILE_MP_BYPASS_EN controls write-to-read forwarding.
REQ-030 Defined: a read with i_r_address[k]==i_w_address and an accepted write in the same cycle returns i_data.
REQ-031 Undefined: such a read returns the pre-write contents; the write still commits.

Structure
REQ-032 Package reg_file_mp_pkg holds the state typedef (IDLE, CLEAR) and default DATA_W/ADDR_W/NUM_RD constants.
REQ-033 One sub-module reg_file_mp_clear_seq holds the FSM, ptr and o_busy, and outputs clear-write enable and address.
REQ-034 Storage array and read ports stay in reg_file_mp, with read ports generated per NUM_RD.

Verification
REQ-035 Write 0xA5 to r3, next cycle read r3 on port 0 and port 1 -> both o_data=0xA5, o_valid=2'b11 one cycle later.
REQ-036 Same-cycle write 0x3C to r5 and read r5, reg previously 0x11 -> 0x3C with BYPASS_EN, 0x11 without.
REQ-037 Fill all 8 regs with nonzero, pulse i_clear -> o_busy high exactly 8 cycles, then all reads return 0x00.
REQ-038 Write r2=0x77 and read r2 during CLEAR -> write dropped, o_valid=0; after sweep r2 reads 0x00.
REQ-039 Assert i_rst at sweep cycle 3 with r7=0x55 -> next cycle o_busy=0, state IDLE, r7 reads 0x00.
REQ-040 Params DATA_W=16, ADDR_W=5, NUM_RD=3: write 0xBEEF to r31, read r31 on all ports -> 0xBEEF on each.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types and default sizes for the multi-port register file
package reg_file_mp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_mp_clear_seq.sv
// rtl/reg_file_mp_clear_seq.sv - background clear sweep FSM, one register zeroed per cycle
module reg_file_mp_clear_seq
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    clr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        o_clr_we   = 1'b0;
        o_clr_addr = ptr;
        case (state)
            IDLE: begin
                if (i_clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                o_clr_we = 1'b1;
                // Leave on the last address rather than letting ptr wrap
                if (ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state == CLEAR);

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - register file, one write port, NUM_RD registered read ports, clear sweep; REG_FILE_MP_BYPASS_EN enables write-to-read forwarding
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD-1:0]        i_r_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_r_address,
    output logic [NUM_RD*DATA_W-1:0] o_data,
    output logic [NUM_RD-1:0]        o_valid,
    input  logic                     i_write,
    input  logic [ADDR_W-1:0]        i_w_address,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_clear,
    output logic                     o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;

    reg_file_mp_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_clear),
        .o_busy     (o_busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // The sweep owns the array while busy, so user writes are simply dropped
    assign wr_acc = i_write & ~o_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[i_w_address] <= i_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rd_word;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              rd_acc;

        assign raddr  = i_r_address[g*ADDR_W +: ADDR_W];
        assign rd_acc = i_r_en[g] & ~o_busy;
`ifdef REG_FILE_MP_BYPASS_EN
        assign rd_word = (wr_acc && (i_w_address == raddr)) ? i_data : mem[raddr];
`else
        assign rd_word = mem[raddr];
`endif

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) data_q <= rd_word;
            end
        end

        assign o_data[g*DATA_W +: DATA_W] = data_q;
        assign o_valid[g]                 = valid_q;
    end

endmodule
